// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store. Data accesses have priority. Fetch is forced through after
// it has been denied MAX_WAIT consecutive cycles. One access is issued per
// cycle, and read data returns one cycle after its grant.
module mem_port_arbiter #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    // load/store port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    input  logic [2:0]        dm_size_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    // memory port
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [2:0]        mem_size_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    localparam logic [2:0] MEM_WORD = 3'b010;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t     resp_owner;
    logic [3:0] starve_cnt;
    logic       if_forced;

    // Fetch overrides data only after it has been starved long enough.
    assign if_forced = if_req_i && (starve_cnt == MAX_CNT);

    // Same-cycle grant selection. Reset masks both grants, so a grant is
    // never issued while rst is high.
    always_comb begin
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        if (!rst) begin
            if (if_forced) begin
                if_gnt_o = 1'b1;
            end else if (dm_req_i) begin
                dm_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    // Route the granted request to the memory port. With no grant, drive zeros.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_size_o  = 3'b000;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
            mem_size_o = MEM_WORD;
            mem_ren_o  = 1'b1;
        end else if (dm_gnt_o) begin
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
            mem_size_o  = dm_size_i;
            mem_ren_o   = ~dm_we_i;
            mem_wen_o   = dm_we_i;
        end
    end

    // Record which requester owns the read data returning next cycle.
    // Stores produce no response, so they leave the owner at NONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner <= OWN_NONE;
        end else if (if_gnt_o) begin
            resp_owner <= OWN_IF;
        end else if (dm_gnt_o && !dm_we_i) begin
            resp_owner <= OWN_DM;
        end else begin
            resp_owner <= OWN_NONE;
        end
    end

    // Count consecutive denied fetch cycles, saturating at MAX_WAIT.
    // The count clears when fetch is granted or stops requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt_o || !if_req_i) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != MAX_CNT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Steer returning read data to its owner. Reset masks any in-flight
    // response, and rdata reads as zero whenever its rvalid is low.
    always_comb begin
        if_rvalid_o = !rst && (resp_owner == OWN_IF);
        dm_rvalid_o = !rst && (resp_owner == OWN_DM);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven checks of grant, memory drive and response
// routing. Hand-written sequences cover starvation rotation and a reset that
// lands on an in-flight fetch.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i, dm_we_i;
    logic [31:0] dm_addr_i, dm_wdata_i;
    logic [2:0]  dm_size_i;
    logic        dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [2:0]  mem_size_o;
    logic        mem_ren_o, mem_wen_o;
    logic [31:0] mem_rdata_i = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_size_i(dm_size_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata_i)
    );

    // Memory model: 256 words indexed by addr[9:2], with 1-cycle read latency.
    // A word that has never been written reads as 0xC00000nn, where nn is its index.
    logic [31:0] mem_q [0:255];
    bit   [255:0] written;
    always @(posedge clk) begin
        if (mem_wen_o) begin
            mem_q[mem_addr_o[9:2]]   <= mem_wdata_o;
            written[mem_addr_o[9:2]] <= 1'b1;
        end
        if (mem_ren_o)
            mem_rdata_i <= written[mem_addr_o[9:2]] ? mem_q[mem_addr_o[9:2]]
                                                    : (32'hC000_0000 | {24'h0, mem_addr_o[9:2]});
    end

    typedef struct {
        bit          rst, ifr;
        logic [31:0] ifa;
        bit          dmr, we;
        logic [31:0] dma, wd;
        logic [2:0]  dsz;
        bit          eig, edg, eiv;
        logic [31:0] eid;
        bit          edv;
        logic [31:0] edd;
        bit          eren, ewen;
        logic [31:0] eaddr, ewd;
        logic [2:0]  esz;
    } vec_t;

    vec_t vq[$];
    int   ncmp = 0;
    int   nerr = 0;

    function automatic void add(bit rs, bit ifr, logic [31:0] ifa, bit dmr, bit we,
                                logic [31:0] dma, logic [31:0] wd, logic [2:0] dsz,
                                bit eig, bit edg, bit eiv, logic [31:0] eid,
                                bit edv, logic [31:0] edd, bit eren, bit ewen,
                                logic [31:0] eaddr, logic [31:0] ewd, logic [2:0] esz);
        vec_t v;
        v.rst = rs; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we;
        v.dma = dma; v.wd = wd; v.dsz = dsz;
        v.eig = eig; v.edg = edg; v.eiv = eiv; v.eid = eid; v.edv = edv; v.edd = edd;
        v.eren = eren; v.ewen = ewen; v.eaddr = eaddr; v.ewd = ewd; v.esz = esz;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rs, input bit ifr, input logic [31:0] ifa, input bit dmr,
                         input bit we, input logic [31:0] dma, input logic [31:0] wd,
                         input logic [2:0] dsz);
        rst = rs; if_req_i = ifr; if_addr_i = ifa; dm_req_i = dmr; dm_we_i = we;
        dm_addr_i = dma; dm_wdata_i = wd; dm_size_i = dsz;
    endtask

    // Drive inputs just after the rising edge, then check on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] A0  = 32'h0100_0000;
    localparam logic [31:0] A10 = 32'h0100_0010;
    localparam logic [31:0] A14 = 32'h0100_0014;
    localparam logic [31:0] AS  = 32'h0100_0100;
    localparam logic [31:0] W1  = 32'h1111_2222;

    initial begin
        //   rst ifr ifa     dmr we dma  wd          dsz   eig edg eiv eid           edv edd           ren wen addr  wdata       size
        // reset held with both requests pending
        add(1, 1, A0,      1, 0, A10, W1,          3'd2, 0, 0, 0, 0,            0, 0,            0, 0, 0,    0,          3'd0);
        add(1, 1, A0,      1, 0, A10, W1,          3'd2, 0, 0, 0, 0,            0, 0,            0, 0, 0,    0,          3'd0);
        // first cycle out of reset: data wins
        add(0, 1, A0,      1, 0, A10, W1,          3'd2, 0, 1, 0, 0,            0, 0,            1, 0, A10,  W1,         3'd2);
        // fetch-only stream, back to back
        add(0, 1, A0,      0, 0, 0,   0,           3'd0, 1, 0, 0, 0,            1, 32'hC0000004, 1, 0, A0,   0,          3'd2);
        add(0, 1, A0 + 4,  0, 0, 0,   0,           3'd0, 1, 0, 1, 32'hC0000000, 0, 0,            1, 0, A0+4, 0,          3'd2);
        add(0, 1, A0 + 8,  0, 0, 0,   0,           3'd0, 1, 0, 1, 32'hC0000001, 0, 0,            1, 0, A0+8, 0,          3'd2);
        add(0, 1, A0 + 12, 0, 0, 0,   0,           3'd0, 1, 0, 1, 32'hC0000002, 0, 0,            1, 0, A0+12,0,          3'd2);
        add(0, 0, 0,       0, 0, 0,   0,           3'd0, 0, 0, 1, 32'hC0000003, 0, 0,            0, 0, 0,    0,          3'd0);
        // store then load of the same word
        add(0, 0, 0,       1, 1, AS,  32'hDEADBEEF,3'd2, 0, 1, 0, 0,            0, 0,            0, 1, AS,   32'hDEADBEEF,3'd2);
        add(0, 0, 0,       1, 0, AS,  0,           3'd2, 0, 1, 0, 0,            0, 0,            1, 0, AS,   0,          3'd2);
        add(0, 0, 0,       0, 0, 0,   0,           3'd0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0, 0,    0,          3'd0);
        // interleaved: dm load, then fetch; the responses go to the correct owners
        add(0, 0, 0,       1, 0, A14, 0,           3'd4, 0, 1, 0, 0,            0, 0,            1, 0, A14,  0,          3'd4);
        add(0, 1, A0 + 8,  0, 0, 0,   0,           3'd0, 1, 0, 0, 0,            1, 32'hC0000005, 1, 0, A0+8, 0,          3'd2);
        add(0, 0, 0,       0, 0, 0,   0,           3'd0, 0, 0, 1, 32'hC0000002, 0, 0,            0, 0, 0,    0,          3'd0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].ifr, vq[i].ifa, vq[i].dmr, vq[i].we, vq[i].dma, vq[i].wd, vq[i].dsz);
            @(negedge clk);
            chk($sformatf("v%0d if_gnt", i),      {31'h0, if_gnt_o},    {31'h0, vq[i].eig});
            chk($sformatf("v%0d dm_gnt", i),      {31'h0, dm_gnt_o},    {31'h0, vq[i].edg});
            chk($sformatf("v%0d if_rvalid", i),   {31'h0, if_rvalid_o}, {31'h0, vq[i].eiv});
            chk($sformatf("v%0d if_rdata", i),    if_rdata_o,           vq[i].eid);
            chk($sformatf("v%0d dm_rvalid", i),   {31'h0, dm_rvalid_o}, {31'h0, vq[i].edv});
            chk($sformatf("v%0d dm_rdata", i),    dm_rdata_o,           vq[i].edd);
            chk($sformatf("v%0d mem_ren", i),     {31'h0, mem_ren_o},   {31'h0, vq[i].eren});
            chk($sformatf("v%0d mem_wen", i),     {31'h0, mem_wen_o},   {31'h0, vq[i].ewen});
            chk($sformatf("v%0d mem_addr", i),    mem_addr_o,           vq[i].eaddr);
            chk($sformatf("v%0d mem_wdata", i),   mem_wdata_o,          vq[i].ewd);
            chk($sformatf("v%0d mem_size", i),    {29'h0, mem_size_o},  {29'h0, vq[i].esz});
            next_cycle();
        end

        // Contention: both requests held, so fetch wins every 5th cycle.
        // The last cycle (k=14) is a fetch grant.
        for (int k = 0; k < 15; k++) begin
            drive(0, 1, A0, 1, 0, A10, 0, 3'd2);
            @(negedge clk);
            chk($sformatf("cont%0d if_gnt", k), {31'h0, if_gnt_o}, {31'h0, (k % 5) == 4});
            chk($sformatf("cont%0d dm_gnt", k), {31'h0, dm_gnt_o}, {31'h0, (k % 5) != 4});
            chk($sformatf("cont%0d both", k),   {31'h0, if_gnt_o & dm_gnt_o}, 32'h0);
            next_cycle();
        end

        // Reset lands on the fetch response. Nothing is granted, and no rvalid appears.
        drive(1, 1, A0, 1, 0, A10, 0, 3'd2);
        @(negedge clk);
        chk("rstmid if_gnt",    {31'h0, if_gnt_o},    32'h0);
        chk("rstmid dm_gnt",    {31'h0, dm_gnt_o},    32'h0);
        chk("rstmid if_rvalid", {31'h0, if_rvalid_o}, 32'h0);
        chk("rstmid if_rdata",  if_rdata_o,           32'h0);
        chk("rstmid mem_ren",   {31'h0, mem_ren_o},   32'h0);
        next_cycle();

        // After release, the starvation count restarts at 0: dm x4, then if.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, A0, 1, 0, A10, 0, 3'd2);
            @(negedge clk);
            if (k == 0) begin
                chk("rel if_rvalid", {31'h0, if_rvalid_o}, 32'h0);
                chk("rel dm_rvalid", {31'h0, dm_rvalid_o}, 32'h0);
            end
            chk($sformatf("rel%0d if_gnt", k), {31'h0, if_gnt_o}, {31'h0, k == 4});
            chk($sformatf("rel%0d dm_gnt", k), {31'h0, dm_gnt_o}, {31'h0, k != 4});
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
